uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter OVS, default 16: oversample ticks per bit, even, 8..32.
REQ-003 Parameter DIV, default 1: clk cycles per oversample tick, at least 1.
REQ-004 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, at least 2.
REQ-005 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only under UART_RX_PARITY_EN.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 rx  input  1  asynchronous serial line; idle high, LSB first.
REQ-009 data  output  DATA_BITS  FIFO head word.
REQ-010 valid  output  1  FIFO not empty; data is meaningful.
REQ-011 ready  input  1  consumer accepts data when valid && ready.
REQ-012 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-013 parity_err  output  1  one-cycle pulse on a parity mismatch.
REQ-014 overrun  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (rxs).
REQ-016 A tick SHALL assert for one clk every DIV cycles from a free-running divider that restarts at 0 on each IDLE-to-START transition.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-018 IDLE: rxs==0 SHALL move to START and clear the tick counter.
REQ-019 START: after OVS/2 ticks, rxs==0 SHALL move to DATA; rxs==1 SHALL return to IDLE as a glitch, with no flags and no push.
REQ-020 DATA: rxs SHALL be sampled every OVS ticks, shifted in LSB first, for exactly DATA_BITS samples; the FSM then moves to PARITY (macro defined) or STOP.
REQ-021 STOP: rxs SHALL be sampled after OVS ticks; rxs==1 with no parity error pushes the word and moves to IDLE.
REQ-022 STOP with rxs==0 SHALL pulse frame_err, discard the word, and move to BREAK.
REQ-023 BREAK SHALL hold until rxs==1, then move to IDLE.
REQ-024 Frame latency SHALL be the first push at most OVS*DIV*(DATA_BITS+1.5)+DIV+4 clk after the rx falling edge; valid rises the cycle after the push.
REQ-025 The FIFO SHALL be first-word fall-through: data = head while valid; a pop occurs on valid && ready.
REQ-026 A push when full with no same-cycle pop SHALL drop the new word and pulse overrun; FIFO contents remain unchanged.
REQ-027 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full.
REQ-028 A pop when empty SHALL be ignored.
REQ-029 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are derived from the MSB and the low bits.
REQ-030 All error and overrun outputs SHALL be registered and high for exactly one clk per event.

Reset
REQ-031 reset SHALL put the FSM in IDLE, clear the shift register, tick and bit counters and FIFO pointers, and set the synchronizer flops to 1.
REQ-032 During and after reset: valid=0, data=0, frame_err=0, parity_err=0, overrun=0.
REQ-033 reset mid-frame SHALL abandon the frame without a push or flag; reception resumes at the next falling edge after reset deasserts.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: the PARITY state samples one bit OVS ticks after the last data bit; XOR of the data bits and the parity bit must equal PARITY_ODD. On mismatch the FSM continues to STOP, parity_err pulses at the stop sample, and the word is discarded.
REQ-035 Macro UART_RX_PARITY_EN undefined: no PARITY state or parity logic; the frame is start+DATA_BITS+stop and parity_err is tied to 0.

Verification (DIV=1, OVS=16, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
REQ-036 Send 0xA5 at 16 clk/bit with ready=1 -> data=0xA5, valid high for 1 clk, no flags.
REQ-037 Send 0x01,0x02,0x03,0x04,0x05 with ready=0 -> overrun pulses once, on the fifth stop; then raising ready pops 0x01..0x04 in order and valid falls.
REQ-038 Send 0x3C with stop bit driven 0, holding rx low 40 clk -> frame_err pulses once, no push, FSM stays in BREAK until rx=1, then the next 0x3C is received.
REQ-039 Drive a 4-clk low glitch on idle rx -> no push, no flags, FSM back in IDLE by clk 12.
REQ-040 With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err pulse, no push; resend with parity bit 1 -> data=0x07.
REQ-041 Assert reset at data bit 4 of 0xFF, then send 0x55 -> only 0x55 appears, valid=0 during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word fall-through FIFO.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx         in   asynchronous serial line (idle high, LSB first)
//   data       out  FIFO head word (0 while empty)
//   valid      out  FIFO not empty
//   ready      in   consumer accepts head word when valid && ready
//   frame_err  out  one-cycle pulse on a bad (low) stop bit
//   parity_err out  one-cycle pulse on a parity mismatch (0 unless parity enabled)
//   overrun    out  one-cycle pulse when a good word is dropped on a full FIFO
//
// Build option: define UART_RX_PARITY_EN to receive a parity bit between the
// last data bit and the stop bit (even parity unless PARITY_ODD=1).
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVS        = 16,
  parameter int unsigned DIV        = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned TICK_W = $clog2(OVS + 1);
  localparam int unsigned DIV_W  = $clog2(DIV + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // Elaboration-time parameter legality checks
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_fifo: DATA_BITS must be 5..9");
  end
  if (OVS < 8 || OVS > 32 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_fifo: OVS must be even, 8..32");
  end
  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_fifo: DIV must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rxs_q, rxs_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic tick;
  logic push;
  logic pop;
  logic do_push;
  logic empty;
  logic full;
  logic par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
  // XOR of data and parity bit must equal PARITY_ODD
  assign par_bad = ((^shreg_q) ^ par_q) != 1'(PARITY_ODD);
`else
  assign par_bad = 1'b0;
`endif

  // Receiver next-state and datapath
  always_comb begin
    state_d     = state_q;
    rx_meta_d   = rx;
    rxs_d       = rx_meta_q;
    tick        = (div_cnt_q == DIV_LAST);
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          div_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxs_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shreg_d    = {rxs_q, shreg_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            par_d      = rxs_q;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad;
`endif
            if (rxs_q) begin
              push    = !par_bad;
              state_d = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty
  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    pop       = !empty && ready;
    do_push   = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    mem_d     = mem_q;
    if (do_push) mem_d[wr_ptr_q[ADDR_W-1:0]] = shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rxs_q       <= rxs_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage needs no reset: data is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign valid     = !empty;
  assign data      = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven and randomized bench for uart_rx_fifo at
// DIV=1, OVS=16, DATA_BITS=8, FIFO_DEPTH=4 (16 clk per bit).
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 16;
  localparam logic PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MAX = 16 * 10 + 8 + 1 + 4 + 1;
`else
  localparam int LAT_MAX = 16 * 9 + 8 + 1 + 4 + 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  int total = 0;
  int bad   = 0;

  // Observed behaviour, accumulated on the falling edge
  logic [7:0] popped[$];
  int  ferr_cnt, perr_cnt, ovr_cnt, valid_cycles;
  time t_rise, t_start;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && ready) popped.push_back(data);
      if (valid) valid_cycles++;
      if (valid && !valid_prev) t_rise = $time;
      if (frame_err) ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (overrun) ovr_cnt++;
    end
    valid_prev = valid;
  end

  task automatic clear_mon();
    popped.delete();
    ferr_cnt = 0; perr_cnt = 0; ovr_cnt = 0; valid_cycles = 0; t_rise = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(BIT_CLK);
  endtask

  // One frame; a low stop bit is held low for 'hold' clk before releasing
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par_flip, input int hold);
    t_start = $time;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PODD ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    if (stop) begin
      drive_bit(1'b1);
    end else begin
      rx = 1'b0;
      idle(hold);
      rx = 1'b1;
    end
  endtask

  function automatic int head(input int idx);
    return (popped.size() > idx) ? int'(popped[idx]) : -1;
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_pops;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] exp_q[$];
    int exp_ferr;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h5A, 1'b0, 0, 1};
    vecs[6] = '{8'h01, 1'b1, 1, 0};

    // Reset state
    reset = 1'b1; rx = 1'b1; ready = 1'b0;
    clear_mon();
    idle(3);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    idle(5);
    chk("post_rst_valid", int'(valid), 0);

    // Table-driven single frames, consumer always ready
    ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      clear_mon();
      send_frame(vecs[k].d, vecs[k].stop, 1'b0, 40);
      idle(20);
      chk($sformatf("vec%0d_pops", k), popped.size(), vecs[k].exp_pops);
      chk($sformatf("vec%0d_ferr", k), ferr_cnt, vecs[k].exp_ferr);
      chk($sformatf("vec%0d_perr", k), perr_cnt, 0);
      chk($sformatf("vec%0d_ovr", k), ovr_cnt, 0);
      chk($sformatf("vec%0d_valid_cycles", k), valid_cycles, vecs[k].exp_pops);
      if (vecs[k].exp_pops == 1) begin
        chk($sformatf("vec%0d_data", k), head(0), int'(vecs[k].d));
        chk($sformatf("vec%0d_latency_ok", k),
            (t_rise > t_start && (t_rise - t_start) / 10 <= LAT_MAX) ? 1 : 0, 1);
      end
    end

    // Overrun: five words into a 4-deep FIFO with no consumer
    ready = 1'b0;
    clear_mon();
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b0, 0);
      idle(10);
      if (k == 4) chk("ovr_before_fifth", ovr_cnt, 0);
    end
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_valid_held", int'(valid), 1);
    chk("ovr_head", int'(data), 1);
    ready = 1'b1;
    idle(10);
    chk("ovr_pops", popped.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ovr_pop%0d", i), head(i), i + 1);
    chk("ovr_valid_fall", int'(valid), 0);

    // Bad stop, long break, then a clean frame
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 200);
    chk("brk_ferr", ferr_cnt, 1);
    chk("brk_pops", popped.size(), 0);
    idle(4);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle(20);
    chk("brk_next_pops", popped.size(), 1);
    chk("brk_next_data", head(0), 8'h3C);
    chk("brk_ferr_once", ferr_cnt, 1);

    // 4-clk glitch, then a frame starting 12 clk after the glitch began
    clear_mon();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(8);
    send_frame(8'h96, 1'b1, 1'b0, 0);
    idle(20);
    chk("glitch_pops", popped.size(), 1);
    chk("glitch_data", head(0), 8'h96);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_perr", perr_cnt, 0);

    // Reset mid-frame with a word already queued
    ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, 1'b0, 0);
    idle(10);
    chk("mid_rst_queued", int'(valid), 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    idle(8);
    reset = 1'b1;
    idle(1);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_data", int'(data), 0);
    idle(3);
    chk("mid_rst_valid_hold", int'(valid), 0);
    reset = 1'b0;
    ready = 1'b1;
    clear_mon();
    idle(200);
    chk("mid_rst_no_pops", popped.size(), 0);
    chk("mid_rst_no_ferr", ferr_cnt, 0);
    send_frame(8'h55, 1'b1, 1'b0, 0);
    idle(20);
    chk("mid_rst_pops", popped.size(), 1);
    chk("mid_rst_data55", head(0), 8'h55);

`ifdef UART_RX_PARITY_EN
    // Wrong parity is flagged and dropped; correct parity is received
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(20);
    chk("par_bad_perr", perr_cnt, 1);
    chk("par_bad_pops", popped.size(), 0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(20);
    chk("par_ok_perr", perr_cnt, 0);
    chk("par_ok_data", head(0), 8'h07);
`endif

    // Random frames against a queue model of the receiver
    clear_mon();
    exp_ferr = 0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      logic       stop;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop, 1'b0, int'($urandom_range(20, 60)));
      if (stop) exp_q.push_back(d);
      else exp_ferr++;
      idle(int'($urandom_range(2, 30)));
    end
    idle(20);
    chk("rnd_pops", popped.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("rnd_data%0d", i), head(i), int'(exp_q[i]));
    chk("rnd_ferr", ferr_cnt, exp_ferr);
    chk("rnd_ovr", ovr_cnt, 0);
    chk("rnd_perr", perr_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
